// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the scan FSM state encoding, the key-code mapping and a counter-width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  function automatic int code_of(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, WIDTH bits wide, for asynchronous inputs.
// The output is all-zero while reset is held.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_p0;
  logic [WIDTH-1:0] r_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
    end else begin
      r_p0 <= i_d;
      r_p1 <= r_p0;
    end
  end

  assign o_q = r_p1;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sensing, debounced
// press/release, optional auto-repeat, and key-code delivery over valid/ready.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 3,
  parameter int SCAN_DWELL      = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  localparam int CW             = width_of(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [NUM_COLS-1:0] columns,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [CW-1:0]       key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_down,
  output logic                overrun
);

  localparam int RW = width_of(NUM_ROWS);
  localparam int IW = width_of(NUM_COLS);
  localparam int DW = width_of(SCAN_DWELL);
  localparam int BW = width_of(DEBOUNCE_CYCLES);
  localparam int PW = width_of((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  logic                w_rst_n;
  logic [NUM_ROWS-1:0] w_rows_s;
  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt, w_idx_adv;
  logic [DW-1:0]       r_dwell, w_dwell_nxt;
  logic [BW-1:0]       r_cnt, w_cnt_nxt;
  logic [RW-1:0]       r_row, w_row_nxt, w_low_row;
  logic [PW-1:0]       r_rep, w_rep_nxt;
  logic                r_rep_first, w_rep_first_nxt;
  logic [NUM_COLS-1:0] r_columns;
  logic [CW-1:0]       r_key_code, w_code;
  logic                r_key_valid, r_key_down, w_down_nxt, r_overrun;
  logic                w_row_hi, w_emit;

  // Reset asserts asynchronously but is released on a clock edge.
  sync2 #(.WIDTH(1)) u_rst_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (1'b1),
    .o_q   (w_rst_n)
  );

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (w_rst_n),
    .i_d   (rows),
    .o_q   (w_rows_s)
  );

  always_comb begin
    w_low_row = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (w_rows_s[r]) w_low_row = RW'(r);
    end
  end

  assign w_row_hi  = w_rows_s[r_row];
  assign w_idx_adv = (r_idx == IW'(NUM_COLS - 1)) ? '0 : r_idx + 1'b1;
  assign w_code    = CW'(code_of(int'(r_row), int'(r_idx), NUM_COLS));

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_dwell_nxt     = r_dwell;
    w_cnt_nxt       = r_cnt;
    w_row_nxt       = r_row;
    w_rep_nxt       = r_rep;
    w_rep_first_nxt = r_rep_first;
    w_down_nxt      = r_key_down;
    w_emit          = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_dwell == DW'(SCAN_DWELL - 1)) begin
          w_dwell_nxt = '0;
          if (|w_rows_s) begin
            w_row_nxt   = w_low_row;
            w_cnt_nxt   = '0;
            w_state_nxt = DEB_PRESS;
          end else begin
            w_idx_nxt = w_idx_adv;
          end
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!w_row_hi) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = w_idx_adv;
          w_state_nxt = SCAN;
        end else if (r_cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
          w_emit          = 1'b1;
          w_down_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          w_rep_nxt       = '0;
          w_rep_first_nxt = 1'b1;
          w_state_nxt     = HELD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_row_hi) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DEB_RELEASE;
        end else if (REPEAT_EN != 0) begin
          // Repeat timer only runs while held; a release bounce freezes it.
          if (r_rep == (r_rep_first ? PW'(REPEAT_DELAY - 1) : PW'(REPEAT_RATE - 1))) begin
            w_emit          = 1'b1;
            w_rep_nxt       = '0;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_rep_nxt = r_rep + 1'b1;
          end
        end
      end
      DEB_RELEASE: begin
        if (w_row_hi) begin
          w_cnt_nxt   = '0;
          w_state_nxt = HELD;
        end else if (r_cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_down_nxt  = 1'b0;
          w_idx_nxt   = w_idx_adv;
          w_state_nxt = SCAN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= SCAN;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_row       <= '0;
      r_rep       <= '0;
      r_rep_first <= 1'b0;
      r_columns   <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dwell     <= w_dwell_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row       <= w_row_nxt;
      r_rep       <= w_rep_nxt;
      r_rep_first <= w_rep_first_nxt;
      r_columns   <= NUM_COLS'(1) << w_idx_nxt;
      r_key_down  <= w_down_nxt;
      // A new event may replace one that is being accepted this same cycle.
      if (w_emit) begin
        if (!r_key_valid || key_ready) begin
          r_key_code  <= w_code;
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (key_ready) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign columns   = r_columns;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from columns,
// and transfers are logged at the falling edge for checking against hand-computed values.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int NR = 4;
  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NC-1:0] columns, columns_r;
  logic [NR-1:0] rows, rows_r;
  logic [3:0]    key_code, key_code_r;
  logic          key_valid, key_valid_r, key_ready, key_ready_r;
  logic          key_down, key_down_r, overrun, overrun_r;
  logic [11:0]   keys, keys_r;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic onehot_bad = 1'b0;
  int   ev_code[$], ev_cyc[$], rev_code[$], rev_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8), .REPEAT_EN(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .columns(columns), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_down(key_down), .overrun(overrun)
  );

  keypad_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8), .REPEAT_EN(1),
    .REPEAT_DELAY(50), .REPEAT_RATE(20)
  ) dut_r (
    .clk(clk), .reset_n(reset_n), .columns(columns_r), .rows(rows_r),
    .key_code(key_code_r), .key_valid(key_valid_r), .key_ready(key_ready_r),
    .key_down(key_down_r), .overrun(overrun_r)
  );

  // Keypad model: a pressed key connects its column line to its row line.
  always_comb begin
    rows   = '0;
    rows_r = '0;
    for (int r = 0; r < NR; r++) begin
      rows[r]   = |(keys[r*NC +: NC] & columns);
      rows_r[r] = |(keys_r[r*NC +: NC] & columns_r);
    end
  end

  always @(negedge clk) begin
    if (key_valid && key_ready) begin
      ev_code.push_back(int'(key_code));
      ev_cyc.push_back(cyc);
    end
    if (key_valid_r && key_ready_r) begin
      rev_code.push_back(int'(key_code_r));
      rev_cyc.push_back(cyc);
    end
    if (!$onehot0(columns) || !$onehot0(columns_r)) onehot_bad = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input int n0, input int limit, input string tag);
    int i = 0;
    while (ev_code.size() <= n0 && i < limit) begin
      step(1);
      i++;
    end
    check_eq(tag, ev_code.size() > n0, 1);
  endtask

  task automatic wait_down(input logic v, input int limit, input string tag);
    int i = 0;
    while (key_down !== v && i < limit) begin
      step(1);
      i++;
    end
    check_eq(tag, key_down, v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n0, n1, t0, lat, rel, i;
    logic [NC-1:0] prev;
    reset_n     = 1'b0;
    key_ready   = 1'b1;
    key_ready_r = 1'b1;
    keys        = '0;
    keys_r      = '0;
    step(4);
    check_eq("rst_columns", columns, 0);
    check_eq("rst_key_code", key_code, 0);
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_key_down", key_down, 0);
    check_eq("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    step(10);

    // 1: clean press of code 11, hold, release.
    n0 = ev_code.size();
    keys[11] = 1'b1;
    t0 = cyc;
    wait_ev(n0, 30, "c1_event_seen");
    if (ev_code.size() > n0) begin
      check_eq("c1_code", ev_code[n0], 11);
      lat = ev_cyc[n0] - t0;
      check_eq("c1_latency_in_11_to_23", (lat >= 11 && lat <= 23), 1);
    end
    check_eq("c1_key_down_set", key_down, 1);
    step(200);
    check_eq("c1_single_event", ev_code.size() - n0, 1);
    keys[11] = 1'b0;
    // 2 sync flops + 1 HELD exit + 8 debounce samples.
    step(10);
    check_eq("c1_down_still_held", key_down, 1);
    step(1);
    check_eq("c1_down_released", key_down, 0);
    step(20);
    check_eq("c1_no_extra_event", ev_code.size() - n0, 1);

    // 2: bouncing key at (1,0) never qualifies.
    n0 = ev_code.size();
    for (int k = 0; k < 10; k++) begin
      keys[3] = 1'b1;
      step(5);
      keys[3] = 1'b0;
      step(5);
    end
    step(30);
    check_eq("c2_no_event", ev_code.size() - n0, 0);
    check_eq("c2_key_down", key_down, 0);
    prev = columns;
    n1 = 0;
    i  = 0;
    while (n1 < 4 && i < 60) begin
      step(1);
      i++;
      if (columns !== prev) begin
        check_eq("c2_col_rotate", columns, {prev[NC-2:0], prev[NC-1]});
        prev = columns;
        n1++;
      end
    end
    check_eq("c2_col_transitions", n1, 4);

    // 3: consumer stalled, second event is dropped and flagged.
    key_ready = 1'b0;
    keys[4] = 1'b1;
    i = 0;
    while (key_valid !== 1'b1 && i < 40) begin
      step(1);
      i++;
    end
    check_eq("c3_valid_code4", key_valid, 1);
    check_eq("c3_code4", key_code, 4);
    keys[4] = 1'b0;
    wait_down(1'b0, 40, "c3_release4");
    keys[0] = 1'b1;
    wait_down(1'b1, 80, "c3_press0");
    check_eq("c3_overrun", overrun, 1);
    check_eq("c3_valid_kept", key_valid, 1);
    check_eq("c3_code_kept", key_code, 4);
    keys[0] = 1'b0;
    wait_down(1'b0, 40, "c3_release0");
    n0 = ev_code.size();
    key_ready = 1'b1;
    step(1);
    check_eq("c3_one_transfer", ev_code.size() - n0, 1);
    if (ev_code.size() > n0) check_eq("c3_transfer_code", ev_code[n0], 4);
    check_eq("c3_valid_cleared", key_valid, 0);
    step(10);
    check_eq("c3_no_more_transfer", ev_code.size() - n0, 1);
    check_eq("c3_overrun_sticky", overrun, 1);

    // 4: a second key is ignored while the first is held.
    n0 = ev_code.size();
    keys[5] = 1'b1;
    wait_ev(n0, 40, "c4_event5_seen");
    if (ev_code.size() > n0) check_eq("c4_code5", ev_code[n0], 5);
    keys[3] = 1'b1;
    step(100);
    check_eq("c4_no_event3_while_held", ev_code.size() - n0, 1);
    n1 = ev_code.size();
    keys[5] = 1'b0;
    rel = cyc;
    wait_ev(n1, 80, "c4_event3_seen");
    if (ev_code.size() > n1) begin
      check_eq("c4_code3", ev_code[n1], 3);
      check_eq("c4_after_release_debounce", (ev_cyc[n1] - rel) >= 12, 1);
    end
    keys[3] = 1'b0;
    wait_down(1'b0, 40, "c4_release3");

    // 5: auto-repeat on the second instance.
    n0 = rev_code.size();
    keys_r[7] = 1'b1;
    i = 0;
    while (rev_code.size() <= n0 && i < 40) begin
      step(1);
      i++;
    end
    check_eq("c5_first_seen", rev_code.size() > n0, 1);
    step(200);
    keys_r[7] = 1'b0;
    step(40);
    check_eq("c5_down_released", key_down_r, 0);
    check_eq("c5_event_count", rev_code.size() - n0, 9);
    if (rev_code.size() >= n0 + 5) begin
      check_eq("c5_gap1", rev_cyc[n0+1] - rev_cyc[n0], 50);
      check_eq("c5_gap2", rev_cyc[n0+2] - rev_cyc[n0+1], 20);
      check_eq("c5_gap3", rev_cyc[n0+3] - rev_cyc[n0+2], 20);
      check_eq("c5_gap4", rev_cyc[n0+4] - rev_cyc[n0+3], 20);
      for (int k = 0; k < 5; k++) check_eq("c5_code7", rev_code[n0+k], 7);
    end

    // 6: reset in the middle of a press debounce.
    n0 = ev_code.size();
    keys[0] = 1'b1;
    i = 0;
    while (dut.r_state != DEB_PRESS && i < 40) begin
      step(1);
      i++;
    end
    check_eq("c6_reached_deb_press", dut.r_state == DEB_PRESS, 1);
    step(2);
    reset_n = 1'b0;
    keys[0] = 1'b0;
    #1;
    check_eq("c6_columns", columns, 0);
    check_eq("c6_key_code", key_code, 0);
    check_eq("c6_key_valid", key_valid, 0);
    check_eq("c6_key_down", key_down, 0);
    check_eq("c6_overrun", overrun, 0);
    step(3);
    reset_n = 1'b1;
    step(4);
    check_eq("c6_columns_restart", columns, 3'b001);
    step(80);
    check_eq("c6_no_event", ev_code.size() - n0, 0);

    check_eq("columns_onehot0", onehot_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
